// File: rtl/rom_cache_refill.sv
// Fetch-side refill controller for the direct-mapped instruction ROM cache; misses pull a 4-word line beat by beat.
// Optional hit/miss counters are built only when ROM_CACHE_REFILL_STATS_EN is defined.

package rv32i;
    localparam int CACHE_LENGTH        = 16;
    localparam int CACHE_WORD_ADR_SIZE = 2;
    localparam int CACHE_INDEX_SIZE    = $clog2(CACHE_LENGTH);
    localparam int CACHE_TAG_SIZE      = 30 - CACHE_INDEX_SIZE - CACHE_WORD_ADR_SIZE;

    typedef struct packed {
        logic [CACHE_TAG_SIZE-1:0]      tag;
        logic [CACHE_INDEX_SIZE-1:0]    index;
        logic [CACHE_WORD_ADR_SIZE-1:0] word_addr;
    } rv32i_rom_cache_key_s;

    typedef enum logic {
        CACHE_LOAD  = 1'b0,
        CACHE_STORE = 1'b1
    } cache_op_e;
endpackage

module rom_cache_refill
    import rv32i::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        fetch_req,
    input  logic [31:0]                                 fetch_addr,
    output logic                                        fetch_ready,
    output logic                                        fetch_rvalid,
    output logic [31:0]                                 fetch_rdata,
    output rv32i_rom_cache_key_s                        cache_addr,
    output logic [2**CACHE_WORD_ADR_SIZE-1:0][31:0]     cache_wdata,
    output cache_op_e                                   cache_op,
    input  logic                                        cache_hit,
    input  logic [31:0]                                 cache_rdata,
    output logic                                        mem_req,
    output logic [31:0]                                 mem_addr,
    input  logic                                        mem_rvalid,
    input  logic [31:0]                                 mem_rdata,
    output logic [31:0]                                 stat_hits,
    output logic [31:0]                                 stat_misses
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    logic [1:0]                                 r_state;
    logic [29:0]                                r_addr;
    logic [CACHE_WORD_ADR_SIZE-1:0]             r_beat;
    logic [2**CACHE_WORD_ADR_SIZE-1:0][31:0]    r_line;

    logic w_lookupHit;
    logic w_lookupMiss;
    logic w_unusedAddrBits;

    assign w_unusedAddrBits = ^fetch_addr[1:0];

    assign w_lookupHit  = (r_state == S_LOOKUP) &&  cache_hit;
    assign w_lookupMiss = (r_state == S_LOOKUP) && !cache_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_req) begin
                        r_addr  <= fetch_addr[31:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_beat  <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Only one beat is outstanding, so each response belongs to r_beat.
                    if (mem_rvalid) begin
                        r_line[r_beat] <= mem_rdata;
                        r_beat         <= r_beat + 1'b1;
                        if (r_beat == '1) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All cache/memory-side outputs decode from registered state only.
    assign fetch_ready  = (r_state == S_IDLE) && !rst;
    assign fetch_rvalid = w_lookupHit || (r_state == S_WRITE);
    assign fetch_rdata  = fetch_rvalid ? cache_rdata : '0;

    assign cache_addr  = rv32i_rom_cache_key_s'(r_addr);
    assign cache_wdata = r_line;
    assign cache_op    = (r_state == S_WRITE) ? CACHE_STORE : CACHE_LOAD;

    assign mem_req  = (r_state == S_FILL);
    assign mem_addr = (r_state == S_FILL)
                    ? {r_addr[29:CACHE_WORD_ADR_SIZE], r_beat, 2'b00}
                    : '0;

`ifdef ROM_CACHE_REFILL_STATS_EN
    logic [31:0] r_statHits;
    logic [31:0] r_statMisses;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_statHits   <= '0;
            r_statMisses <= '0;
        end else begin
            if (w_lookupHit && (r_statHits != '1)) begin
                r_statHits <= r_statHits + 32'd1;
            end
            if (w_lookupMiss && (r_statMisses != '1)) begin
                r_statMisses <= r_statMisses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_statHits;
    assign stat_misses = r_statMisses;
`else
    logic w_unusedMissFlag;

    assign w_unusedMissFlag = w_lookupMiss;
    assign stat_hits        = '0;
    assign stat_misses      = '0;
`endif

endmodule

// File: tb/tb_rom_cache_refill.sv
// Directed bench for rom_cache_refill: a behavioural direct-mapped cache plus a ROM whose word at address A is ~A.
// Stats expectations follow ROM_CACHE_REFILL_STATS_EN.

module tb_rom_cache_refill;
    import rv32i::*;

`ifdef ROM_CACHE_REFILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   fetch_req;
    logic [31:0]            fetch_addr;
    logic                   fetch_ready;
    logic                   fetch_rvalid;
    logic [31:0]            fetch_rdata;
    rv32i_rom_cache_key_s   cache_addr;
    logic [3:0][31:0]       cache_wdata;
    cache_op_e              cache_op;
    logic                   cache_hit;
    logic [31:0]            cache_rdata;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_rvalid = 1'b0;
    logic [31:0]            mem_rdata  = '0;
    logic [31:0]            stat_hits;
    logic [31:0]            stat_misses;

    int checkCount = 0;
    int errorCount = 0;

    int   waitCycles = 0;
    int   waitCnt    = 0;
    logic spurious   = 1'b0;

    logic [31:0] beatAddrs[$];
    int          storeCount       = 0;
    int          reqCycles        = 0;
    int          stableViolations = 0;
    logic        prevReq  = 1'b0;
    logic        prevRv   = 1'b0;
    logic        prevRst  = 1'b1;
    logic [31:0] prevAddr = '0;

    logic [15:0]               cacheValid = '0;
    logic [CACHE_TAG_SIZE-1:0] cacheTags  [16];
    logic [3:0][31:0]          cacheLines [16];

    always #5 clk = ~clk;

    rom_cache_refill dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ready  (fetch_ready),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .cache_addr   (cache_addr),
        .cache_wdata  (cache_wdata),
        .cache_op     (cache_op),
        .cache_hit    (cache_hit),
        .cache_rdata  (cache_rdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
    );

    // Cache model: a store forwards the selected write word and forces a hit in the same cycle.
    always_comb begin
        if (cache_op == CACHE_STORE) begin
            cache_hit   = 1'b1;
            cache_rdata = cache_wdata[cache_addr.word_addr];
        end else begin
            cache_hit   = cacheValid[cache_addr.index] && (cacheTags[cache_addr.index] == cache_addr.tag);
            cache_rdata = cacheLines[cache_addr.index][cache_addr.word_addr];
        end
    end

    always @(posedge clk) begin
        if (cache_op == CACHE_STORE) begin
            cacheValid[cache_addr.index] <= 1'b1;
            cacheTags[cache_addr.index]  <= cache_addr.tag;
            cacheLines[cache_addr.index] <= cache_wdata;
        end
    end

    // ROM model: answers after waitCycles idle cycles; spurious injects a response with no request.
    always @(negedge clk) begin
        if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
            waitCnt    = 0;
        end else if (mem_req) begin
            if (waitCnt == waitCycles) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~mem_addr;
                waitCnt    = 0;
            end else begin
                mem_rvalid = 1'b0;
                waitCnt    = waitCnt + 1;
            end
        end else begin
            mem_rvalid = 1'b0;
            waitCnt    = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_rvalid && !rst) beatAddrs.push_back(mem_addr);
        if (mem_req) reqCycles++;
        if (cache_op == CACHE_STORE) storeCount++;
        if (prevReq && !prevRv && !prevRst && (!mem_req || (mem_addr != prevAddr))) stableViolations++;
        prevReq  = mem_req;
        prevRv   = mem_rvalid;
        prevRst  = rst;
        prevAddr = mem_addr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at negedge+1 with the DUT idle; returns with the DUT idle again.
    task automatic applyStimulus(input logic [31:0] addr, output int latency,
                                 output logic [31:0] data, output int readyHigh);
        latency   = -1;
        data      = '0;
        readyHigh = 0;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        @(posedge clk);
        @(negedge clk); #1;
        fetch_req = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (fetch_rvalid) begin
                latency = k;
                data    = fetch_rdata;
                break;
            end
            readyHigh += int'(fetch_ready);
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    task automatic checkBeats(input string tag, input logic [31:0] base);
        checkOutput({tag, "_beatCount"}, beatAddrs.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_beat%0d", tag, i),
                        (i < beatAddrs.size()) ? beatAddrs[i] : 32'hBAD0BAD0,
                        base + 32'(4 * i));
        end
    endtask

    int          lat;
    int          rdy;
    int          rvSeen;
    logic [31:0] data;

    initial begin
        for (int i = 0; i < 16; i++) begin
            cacheTags[i]  = '0;
            cacheLines[i] = '0;
        end
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        repeat (3) @(negedge clk);
        #1;

        checkOutput("rst_fetchReady",  32'(fetch_ready),  32'd0);
        checkOutput("rst_fetchRvalid", 32'(fetch_rvalid), 32'd0);
        checkOutput("rst_fetchRdata",  fetch_rdata,       32'd0);
        checkOutput("rst_memReq",      32'(mem_req),      32'd0);
        checkOutput("rst_memAddr",     mem_addr,          32'd0);
        checkOutput("rst_cacheOp",     32'(cache_op),     32'(CACHE_LOAD));
        checkOutput("rst_cacheAddr",   32'(cache_addr),   32'd0);
        checkOutput("rst_wdata0",      cache_wdata[0],    32'd0);
        checkOutput("rst_wdata3",      cache_wdata[3],    32'd0);
        checkOutput("rst_statHits",    stat_hits,         32'd0);
        checkOutput("rst_statMisses",  stat_misses,       32'd0);

        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_fetchReady", 32'(fetch_ready), 32'd1);

        $display("[TB] cold miss at 0x104");
        beatAddrs.delete();
        storeCount = 0;
        applyStimulus(32'h0000_0104, lat, data, rdy);
        checkOutput("cold_latency", lat, 32'd6);
        checkOutput("cold_data", data, 32'hFFFF_FEFB);
        checkBeats("cold", 32'h0000_0100);
        checkOutput("cold_stores", storeCount, 32'd1);
        checkOutput("cold_wdata3", cache_wdata[3], 32'hFFFF_FEF3);

        $display("[TB] hit at 0x10C");
        reqCycles = 0;
        applyStimulus(32'h0000_010C, lat, data, rdy);
        checkOutput("hit_latency", lat, 32'd1);
        checkOutput("hit_data", data, 32'hFFFF_FEF3);
        checkOutput("hit_memReqCycles", reqCycles, 32'd0);
        checkOutput("hit_statHits", stat_hits, STATS ? 32'd1 : 32'd0);
        checkOutput("hit_statMisses", stat_misses, STATS ? 32'd1 : 32'd0);

        $display("[TB] conflict on index 0");
        applyStimulus(32'h0000_0100, lat, data, rdy);
        checkOutput("conf_hit100_latency", lat, 32'd1);
        checkOutput("conf_hit100_data", data, 32'hFFFF_FEFF);
        applyStimulus(32'h0000_0208, lat, data, rdy);
        checkOutput("conf_miss208_latency", lat, 32'd6);
        checkOutput("conf_miss208_data", data, 32'hFFFF_FDF7);
        applyStimulus(32'h0000_0100, lat, data, rdy);
        checkOutput("conf_remiss100_latency", lat, 32'd6);
        checkOutput("conf_remiss100_data", data, 32'hFFFF_FEFF);

        $display("[TB] miss with 3 wait cycles per beat");
        waitCycles       = 3;
        stableViolations = 0;
        beatAddrs.delete();
        applyStimulus(32'h0000_0340, lat, data, rdy);
        checkOutput("wait_latency", lat, 32'd18);
        checkOutput("wait_data", data, 32'hFFFF_FCBF);
        checkOutput("wait_readyDuringFill", rdy, 32'd0);
        checkOutput("wait_reqStable", stableViolations, 32'd0);
        checkBeats("wait", 32'h0000_0340);
        waitCycles = 0;

        $display("[TB] reset during refill");
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0480;
        @(posedge clk);
        @(negedge clk); #1;
        fetch_req = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
        end
        checkOutput("abort_beat2Addr", mem_addr, 32'h0000_0488);
        rst        = 1'b1;
        storeCount = 0;
        @(negedge clk); #1;
        checkOutput("abort_memReq", 32'(mem_req), 32'd0);
        checkOutput("abort_readyInRst", 32'(fetch_ready), 32'd0);
        checkOutput("abort_wdataCleared", cache_wdata[0], 32'd0);
        rst      = 1'b0;
        spurious = 1'b1;
        @(negedge clk); #1;
        spurious = 1'b0;
        rvSeen   = 0;
        repeat (3) begin
            rvSeen += int'(fetch_rvalid);
            @(negedge clk); #1;
        end
        checkOutput("spur_rvalidSeen", rvSeen, 32'd0);
        checkOutput("spur_memReq", 32'(mem_req), 32'd0);
        checkOutput("spur_ready", 32'(fetch_ready), 32'd1);
        checkOutput("spur_wdata0", cache_wdata[0], 32'd0);
        checkOutput("spur_stores", storeCount, 32'd0);

        beatAddrs.delete();
        applyStimulus(32'h0000_0480, lat, data, rdy);
        checkOutput("refetch_latency", lat, 32'd6);
        checkOutput("refetch_data", data, 32'hFFFF_FB7F);
        checkBeats("refetch", 32'h0000_0480);
        checkOutput("refetch_stores", storeCount, 32'd1);

        $display("[TB] top-of-memory line");
        beatAddrs.delete();
        applyStimulus(32'hFFFF_FFF8, lat, data, rdy);
        checkOutput("wrap_latency", lat, 32'd6);
        checkOutput("wrap_data", data, 32'h0000_0007);
        checkBeats("wrap", 32'hFFFF_FFF0);

        checkOutput("end_statHits", stat_hits, 32'd0);
        checkOutput("end_statMisses", stat_misses, STATS ? 32'd2 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rom_cache_refill.md
# rom_cache_refill

Fetch-side controller for the direct-mapped instruction ROM cache. It accepts instruction-fetch requests from the core and looks each one up in the cache. On a miss it reads the whole 4-word line from ROM memory, one beat at a time, then writes the line into the cache with `CACHE_STORE` and returns the requested word. It sits between the core's fetch stage and the cache, and drives the cache's address, write-data and operation inputs.

## Interface

Parameters: none. `CACHE_LENGTH` and `CACHE_WORD_ADR_SIZE` (=2, four words per line) come from `rv32i` package defines.

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fetch_req`  in  1  core requests a word; sampled only when `fetch_ready`=1
- `fetch_addr`  in  32  byte address; bits [1:0] ignored
- `fetch_ready`  out  1  block can accept a request
- `fetch_rvalid`  out  1  one-cycle pulse; `fetch_rdata` valid
- `fetch_rdata`  out  32  returned instruction word
- `cache_addr`  out  `rv32i_rom_cache_key_s`  key built from latched `fetch_addr[31:2]` as {tag, index, word_addr}
- `cache_wdata`  out  32 x 2**`CACHE_WORD_ADR_SIZE`  line buffer; element n holds word n
- `cache_op`  out  `cache_op_e`  `CACHE_STORE` in WRITE state, otherwise `CACHE_LOAD`
- `cache_hit`  in  1  combinational hit from cache
- `cache_rdata`  in  32  combinational word from cache
- `mem_req`  out  1  beat read request; level signal, held until `mem_rvalid`
- `mem_addr`  out  32  word-aligned beat address {line_base[31:4], beat[1:0], 2'b00}
- `mem_rvalid`  in  1  one-cycle pulse; `mem_rdata` valid
- `mem_rdata`  in  32  beat data
- `stat_hits`  out  32  hit counter (see Configuration)
- `stat_misses`  out  32  miss counter (see Configuration)

## Operation

States: IDLE, LOOKUP, FILL, WRITE.

- **IDLE**
  - `fetch_ready`=1.
  - When `fetch_req`=1, latch `fetch_addr[31:2]` and go to LOOKUP.
- **LOOKUP**
  - Drive `cache_addr` from the latched address, with `cache_op`=`CACHE_LOAD`.
  - If `cache_hit`=1: pulse `fetch_rvalid` with `fetch_rdata`=`cache_rdata`, then go to IDLE.
  - If `cache_hit`=0: clear `beat` to 0 and go to FILL.
- **FILL**
  - `mem_req`=1 and `mem_addr`=line base + `beat`*4.
  - Beats are issued in order 0..3, with one request outstanding at a time.
  - On `mem_rvalid`: store `mem_rdata` to `cache_wdata[beat]` and increment `beat`.
  - When `beat`=3 and `mem_rvalid`=1, go to WRITE.
  - `beat` is a 2-bit counter.
- **WRITE**
  - `cache_op`=`CACHE_STORE` for exactly one cycle.
  - The cache forwards `cache_wdata[word_addr]` on `cache_rdata` and forces `cache_hit`=1. The block pulses `fetch_rvalid` with that word in this same cycle, then goes to IDLE.
- `mem_rvalid` arriving outside FILL is ignored.
- `cache_wdata` holds its contents between refills; it is not cleared.

## Timing

- Reset values:
  - state IDLE, `beat`=0, line buffer 0.
  - `fetch_rvalid`=0, `fetch_rdata`=0, `mem_req`=0, `mem_addr`=0.
  - `cache_op`=`CACHE_LOAD`, stat counters 0.
  - `fetch_ready`=0 while `rst`=1.
- Hit: request accepted at edge N; `fetch_rvalid` is high in cycle N+1. Back-to-back hits give one word every 2 cycles.
- Miss: `fetch_rvalid` is high in the cycle after the 4th `mem_rvalid`. With zero-wait memory, a miss completes in 1 (LOOKUP) + 4 + 1 (WRITE) = 6 cycles.
- `mem_req`, `mem_addr`, `cache_addr` and `cache_op` are decoded from registered state, with no combinational path from `fetch_*` inputs.
- Reset during FILL or WRITE:
  - The line is abandoned and no `CACHE_STORE` is issued after the reset edge.
  - `mem_req`=0 from the first cycle after the edge.
  - A stale `mem_rvalid` after reset is ignored.
- Address wrap: a line at 0xFFFFFFF0 fetches beats 0xFFFFFFF0..0xFFFFFFFC. There is no carry beyond bit 31.

## Configuration

- **`ROM_CACHE_REFILL_STATS_EN` defined:**
  - `stat_hits` increments in LOOKUP on a hit.
  - `stat_misses` increments in LOOKUP on a miss.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- **Not defined:** both ports exist but are tied to 0, and no counter logic is synthesised.

## Test plan

- Reset, then fetch 0x00000104 (cold) with zero-wait memory:
  - `mem_addr` sequence is 0x100, 0x104, 0x108, 0x10C.
  - One `CACHE_STORE` is issued.
  - `fetch_rvalid` arrives 6 cycles after acceptance with the word from 0x104.
- Then fetch 0x0000010C:
  - hit, no `mem_req`, `fetch_rvalid` 1 cycle after acceptance with the 0x10C word.
  - With stats enabled, `stat_hits`=1 and `stat_misses`=1.
- Conflict: fetch 0x100, then an address with the same index but a different tag → miss and refill. Re-fetching 0x100 then misses again.
- Memory inserts 3 wait cycles per beat:
  - `mem_req` and `mem_addr` stay stable until each `mem_rvalid`.
  - `fetch_ready`=0 throughout the refill.
  - Response arrives after the 4th beat.
- Assert `rst` after beat 2 of a refill:
  - no `CACHE_STORE`, `mem_req`=0 the next cycle.
  - a spurious `mem_rvalid` is ignored.
  - re-fetching the same address misses and refills fully.
- Fetch 0xFFFFFFF8 → beats 0xFFFFFFF0..0xFFFFFFFC, returning the word from 0xFFFFFFF8.
